// File: rtl/jtframe_pocket_joymap.sv
// Analogue Pocket controller mapper for JTFRAME: synchronised keys and
// sticks in, SOCD-cleaned directions, autofire and stretched coins out.
module jtframe_pocket_joymap #(
    parameter int         PLAYERS    = 2,
    parameter int         BUTTONS    = 6,
    parameter logic [7:0] ANA_THRESH = 8'd64,
    parameter int         COIN_HOLD  = 3
) (
    input  logic                    clk_sys,
    input  logic                    rst,
    input  logic                    vs,
    input  logic [16*PLAYERS-1:0]   cont_key,
    input  logic [32*PLAYERS-1:0]   cont_joy,
    input  logic                    ana_en,
    input  logic [BUTTONS-1:0]      af_mask,
    input  logic [3:0]              af_rate,
    output logic [32*PLAYERS-1:0]   joystick,
    output logic [PLAYERS-1:0]      but_coin,
    output logic [PLAYERS-1:0]      but_start
);

    localparam logic [8:0] ANA_LO = (ANA_THRESH > 8'd128) ? 9'd0
                                  : 9'd128 - {1'b0, ANA_THRESH};
    localparam logic [8:0] ANA_HI = 9'd128 + {1'b0, ANA_THRESH};
    localparam logic [3:0] HOLD_INIT = 4'(COIN_HOLD);

    typedef enum logic [1:0] {
        C_IDLE,
        C_HOLD,
        C_WAIT
    } coin_st_t;

    logic [16*PLAYERS-1:0] r_key_s1, r_key_s2;
    logic [32*PLAYERS-1:0] r_joy_s1, r_joy_s2;
    logic [1:0]            r_vs;
    logic                  r_tick;
    logic [3:0]            r_af_cnt;
    logic                  r_af_phase;
    logic [1:0]            r_warm;
    logic                  w_sync_ok;

    // The synchroniser holds zeros for two cycles after reset; select edges
    // are only trusted once it carries real key data.
    assign w_sync_ok = r_warm[1];

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_key_s1   <= '0;
            r_key_s2   <= '0;
            r_joy_s1   <= '0;
            r_joy_s2   <= '0;
            r_vs       <= '0;
            r_tick     <= 1'b0;
            r_af_cnt   <= '0;
            r_af_phase <= 1'b0;
            r_warm     <= '0;
        end else begin
            r_key_s1 <= cont_key;
            r_key_s2 <= r_key_s1;
            r_joy_s1 <= cont_joy;
            r_joy_s2 <= r_joy_s1;
            r_vs     <= {r_vs[0], vs};
            r_tick   <= r_vs[0] & ~r_vs[1];
            r_warm   <= {r_warm[0], 1'b1};
            if (r_tick) begin
                if (af_rate == 4'd0) begin
                    r_af_cnt <= '0;
                end else if ({1'b0, r_af_cnt} + 5'd1 >= {1'b0, af_rate}) begin
                    r_af_cnt   <= '0;
                    r_af_phase <= ~r_af_phase;
                end else begin
                    r_af_cnt <= r_af_cnt + 4'd1;
                end
            end
        end
    end

    for (genvar p = 0; p < PLAYERS; p++) begin : g_pl
        logic [15:0]        w_key;
        logic [7:0]         w_x, w_y;
        logic               w_sel;
        logic               w_up_raw, w_dn_raw, w_lf_raw, w_rt_raw;
        logic               w_up, w_dn, w_lf, w_rt;
        logic [BUTTONS-1:0] w_btn;
        logic [31:0]        w_word;
        logic               w_unused_bits;
        logic [31:0]        r_word;
        logic               r_start, r_coin, r_sel_prev;
        logic [3:0]         r_cnt;
        coin_st_t           r_state;

        assign w_key = r_key_s2[16*p +: 16];
        assign w_x   = r_joy_s2[32*p +: 8];
        assign w_y   = r_joy_s2[32*p+8 +: 8];
        assign w_sel = w_key[14];
        assign w_unused_bits = ^{w_key, r_joy_s2[32*p+16 +: 16]};

        always_comb begin
            w_up_raw = w_key[0] | (ana_en & ({1'b0, w_y} < ANA_LO));
            w_dn_raw = w_key[1] | (ana_en & ({1'b0, w_y} > ANA_HI));
            w_lf_raw = w_key[2] | (ana_en & ({1'b0, w_x} < ANA_LO));
            w_rt_raw = w_key[3] | (ana_en & ({1'b0, w_x} > ANA_HI));
            w_up = w_up_raw & ~w_dn_raw;
            w_dn = w_dn_raw & ~w_up_raw;
            w_lf = w_lf_raw & ~w_rt_raw;
            w_rt = w_rt_raw & ~w_lf_raw;
            w_btn = '0;
            for (int i = 0; i < BUTTONS; i++) begin
                if (af_rate == 4'd0 || !af_mask[i])
                    w_btn[i] = w_key[4+i];
                else
                    w_btn[i] = w_key[4+i] & r_af_phase;
            end
            w_word = '0;
            w_word[3:0] = {w_up, w_dn, w_lf, w_rt};
            w_word[4 +: BUTTONS] = w_btn;
        end

        always_ff @(posedge clk_sys) begin
            if (rst) begin
                r_word     <= '0;
                r_start    <= 1'b0;
                r_coin     <= 1'b0;
                r_sel_prev <= 1'b1;
                r_cnt      <= '0;
                r_state    <= C_IDLE;
            end else begin
                r_word     <= w_word;
                r_start    <= w_key[15];
                r_coin     <= (r_state == C_HOLD);
                r_sel_prev <= w_sync_ok ? w_sel : 1'b1;
                unique case (r_state)
                    C_IDLE: begin
                        if (w_sync_ok && w_sel && !r_sel_prev) begin
                            r_state <= C_HOLD;
                            r_cnt   <= HOLD_INIT;
                        end
                    end
                    C_HOLD: begin
                        if (r_tick) begin
                            r_cnt <= r_cnt - 4'd1;
                            if (r_cnt <= 4'd1)
                                r_state <= w_sel ? C_WAIT : C_IDLE;
                        end
                    end
                    C_WAIT: begin
                        if (!w_sel)
                            r_state <= C_IDLE;
                    end
                    default: r_state <= C_IDLE;
                endcase
            end
        end

        assign joystick[32*p +: 32] = r_word;
        assign but_start[p]         = r_start;
        assign but_coin[p]          = r_coin;
    end

endmodule

// File: tb/tb_jtframe_pocket_joymap.sv
// Directed bench for jtframe_pocket_joymap: remap, SOCD, analog, autofire,
// coin stretching and reset behaviour with hand-computed expectations.
module tb_jtframe_pocket_joymap;

    logic        clk_sys = 1'b0;
    logic        rst, vs, ana_en;
    logic [31:0] cont_key;
    logic [63:0] cont_joy;
    logic [5:0]  af_mask;
    logic [3:0]  af_rate;
    logic [63:0] joystick;
    logic [1:0]  but_coin, but_start;
    int          total = 0;
    int          bad = 0;

    jtframe_pocket_joymap #(
        .PLAYERS(2), .BUTTONS(6), .ANA_THRESH(8'd64), .COIN_HOLD(3)
    ) dut (
        .clk_sys(clk_sys), .rst(rst), .vs(vs),
        .cont_key(cont_key), .cont_joy(cont_joy), .ana_en(ana_en),
        .af_mask(af_mask), .af_rate(af_rate), .joystick(joystick),
        .but_coin(but_coin), .but_start(but_start)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic step(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic frame();
        vs = 1'b1;
        step(2);
        vs = 1'b0;
        step(6);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; vs = 1'b0; ana_en = 1'b0;
        cont_key = '0; cont_joy = {32'h8080, 32'h8080};
        af_mask = '0; af_rate = '0;
        step(3);
        chk("rst_joy", joystick, 64'h0);
        chk("rst_coin", {62'b0, but_coin}, 64'h0);
        chk("rst_start", {62'b0, but_start}, 64'h0);
        rst = 1'b0;
        step(2);

        cont_key = 32'h0001;
        step(2);
        chk("lat_joy", joystick, 64'h0);
        step(1);
        chk("up", joystick, 64'h8);
        cont_key = 32'h0008; step(3);
        chk("right", joystick, 64'h1);
        cont_key = 32'h0003; step(3);
        chk("socd_ud", joystick, 64'h0);
        cont_key = 32'h0009; step(3);
        chk("up_right", joystick, 64'h9);
        cont_key = 32'h8010_0000; step(3);
        chk("p2_word", joystick, 64'h0000_0010_0000_0000);
        chk("p2_start", {62'b0, but_start}, 64'h2);

        ana_en = 1'b1; cont_key = '0;
        cont_joy = {32'h8080, 32'h8030}; step(3);
        chk("ana_left", joystick, 64'h2);
        cont_joy[15:0] = 16'h8041; step(3);
        chk("ana_bound", joystick, 64'h0);
        cont_joy[15:0] = 16'h3FC1; step(3);
        chk("ana_up_rt", joystick, 64'h9);
        cont_joy[15:0] = 16'h40C0; step(3);
        chk("ana_edge", joystick, 64'h0);
        ana_en = 1'b0; cont_joy[15:0] = 16'h0000; step(3);
        chk("ana_off", joystick, 64'h0);
        cont_joy = {32'h8080, 32'h8080};

        af_rate = 4'd2; af_mask = 6'b000001; cont_key = 32'h0030;
        step(4);
        chk("af_init", joystick, 64'h20);
        for (int k = 1; k <= 12; k++) begin
            frame();
            chk($sformatf("af_f%0d", k), joystick,
                ((k / 2) % 2 != 0) ? 64'h30 : 64'h20);
        end

        af_rate = 4'd0; cont_key = 32'h4000;
        step(4);
        chk("coin_rise", {62'b0, but_coin}, 64'h1);
        chk("sel_nojoy", joystick, 64'h0);
        for (int k = 1; k <= 10; k++) begin
            frame();
            chk($sformatf("coin_f%0d", k), {62'b0, but_coin},
                (k < 3) ? 64'h1 : 64'h0);
        end
        cont_key = '0; step(4);
        chk("coin_rel", {62'b0, but_coin}, 64'h0);

        cont_key = 32'h4000; step(4);
        chk("coin2_rise", {62'b0, but_coin}, 64'h1);
        frame(); chk("coin2_f1", {62'b0, but_coin}, 64'h1);
        frame(); chk("coin2_f2", {62'b0, but_coin}, 64'h1);
        frame(); chk("coin2_f3", {62'b0, but_coin}, 64'h0);
        cont_key = '0; step(4);

        cont_key = 32'h4000; step(4);
        chk("tog_rise", {62'b0, but_coin}, 64'h1);
        frame(); chk("tog_f1", {62'b0, but_coin}, 64'h1);
        cont_key = '0; step(4);
        cont_key = 32'h4000; step(4);
        chk("tog_mid", {62'b0, but_coin}, 64'h1);
        frame(); chk("tog_f2", {62'b0, but_coin}, 64'h1);
        frame(); chk("tog_f3", {62'b0, but_coin}, 64'h0);
        cont_key = '0; step(4);

        af_rate = 4'd2; af_mask = 6'b000001;
        cont_key = 32'h8000_4010; step(4);
        chk("mid_coin", {62'b0, but_coin}, 64'h1);
        frame(); frame();
        chk("mid_joy", joystick, 64'h10);
        chk("mid_coin2", {62'b0, but_coin}, 64'h1);
        chk("mid_start", {62'b0, but_start}, 64'h2);
        rst = 1'b1; step(1);
        chk("rstm_joy", joystick, 64'h0);
        chk("rstm_coin", {62'b0, but_coin}, 64'h0);
        chk("rstm_start", {62'b0, but_start}, 64'h0);
        step(1);
        rst = 1'b0; step(3);
        chk("post_start", {62'b0, but_start}, 64'h2);
        for (int k = 1; k <= 4; k++) begin
            frame();
            chk($sformatf("post_coin_f%0d", k), {62'b0, but_coin}, 64'h0);
            chk($sformatf("post_joy_f%0d", k), joystick,
                ((k / 2) % 2 != 0) ? 64'h10 : 64'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
